// File: rtl/mem_access_unit.sv
// Purpose: M-stage load/store unit; drives the data-memory port, extends load data, flags misalignment.
// Latency: request accepted in IDLE, one ACCESS cycle, then the response is registered in RESP (min 3 cycles per request).
// Backpressure: req_ready only in IDLE; rsp_valid/rsp_data held in RESP until rsp_ready. Optional macro: MAU_RANGE_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned DM_WORDS = 4096
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_exc,
  output logic [4:0]  rsp_exc_code
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  // The range check folds to a constant when disabled, leaving only alignment checks.
`ifdef MAU_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;

  logic        is_store;
  logic        misalign;
  logic        out_of_range;
  logic        exc_c;
  logic [3:0]  be_c;
  logic [15:0] half_c;
  logic [7:0]  byte_c;
  logic [31:0] load_c;

  // Decode the latched request: store flag, exception, byte enables, extended load data.
  always_comb begin
    is_store     = op_q[2] & (op_q[1] | op_q[0]);
    misalign     = 1'b0;
    be_c         = 4'b0000;
    half_c       = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    byte_c       = 8'h00;
    load_c       = 32'h0;
    out_of_range = RANGE_EN & ({2'b00, addr_q[31:2]} >= DM_WORDS);

    unique case (addr_q[1:0])
      2'd0:    byte_c = dm_rdata[7:0];
      2'd1:    byte_c = dm_rdata[15:8];
      2'd2:    byte_c = dm_rdata[23:16];
      default: byte_c = dm_rdata[31:24];
    endcase

    unique case (op_q)
      OP_LW:   begin misalign = (addr_q[1:0] != 2'b00); load_c = dm_rdata; end
      OP_LH:   begin misalign = addr_q[0]; load_c = {{16{half_c[15]}}, half_c}; end
      OP_LHU:  begin misalign = addr_q[0]; load_c = {16'h0, half_c}; end
      OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_c = {24'h0, byte_c};
      OP_SW:   begin misalign = (addr_q[1:0] != 2'b00); be_c = 4'b1111; end
      OP_SH:   begin misalign = addr_q[0]; be_c = addr_q[1] ? 4'b1100 : 4'b0011; end
      default: be_c = 4'b0001 << addr_q[1:0];
    endcase

    exc_c = misalign | out_of_range;
  end

  // Memory port is live only in ACCESS; a reset in that cycle kills the write.
  always_comb begin
    req_ready = (state == S_IDLE);
    dm_addr   = addr_q;
    dm_wdata  = wdata_q;
    dm_pc     = pc_q;
    dm_be     = (state == S_ACCESS) ? be_c : 4'b0000;
    dm_we     = (state == S_ACCESS) & is_store & ~exc_c & ~Reset;
  end

  // Request FSM: latch in IDLE, register the response at the end of ACCESS, hold it through RESP.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      op_q         <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      pc_q         <= 32'h0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'h0;
      rsp_exc      <= 1'b0;
      rsp_exc_code <= 5'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state        <= S_RESP;
          rsp_valid    <= 1'b1;
          rsp_data     <= exc_c ? 32'h0 : load_c;
          rsp_exc      <= exc_c;
          rsp_exc_code <= exc_c ? (is_store ? 5'd5 : 5'd4) : 5'd0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized transactions against a reference model.
// Response timing is fixed (ACCESS one cycle after accept, RESP the cycle after), so checks are cycle-exact.
// Honours MAU_RANGE_CHECK_EN when the bench is compiled with it.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_exc;
  logic [4:0]  rsp_exc_code;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.DM_WORDS(4096)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_exc(rsp_exc), .rsp_exc_code(rsp_exc_code)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference: op 0..4 loads, 5..7 stores; access size 4/2/1 bytes.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] addr,
                                    input logic [31:0] rdata,
                                    output logic we, output logic [3:0] be,
                                    output logic [31:0] data, output logic exc,
                                    output logic [4:0] code);
    bit          is_load = (op <= 3'd4);
    int unsigned size;
    int unsigned off = addr % 4;
    bit          rng = 1'b0;
    logic [31:0] lane;
    if (op == 3'd0 || op == 3'd5)                   size = 4;
    else if (op == 3'd1 || op == 3'd2 || op == 3'd6) size = 2;
    else                                            size = 1;
`ifdef MAU_RANGE_CHECK_EN
    rng = ((addr / 4) >= 4096);
`endif
    exc  = ((addr % size) != 0) || rng;
    code = exc ? (is_load ? 5'd4 : 5'd5) : 5'd0;
    we   = !is_load && !exc;
    if (is_load)        be = 4'b0000;
    else if (size == 4) be = 4'b1111;
    else if (size == 2) be = 4'(3 << (((addr / 2) % 2) * 2));
    else                be = 4'(1 << off);
    data = 32'h0;
    if (is_load && !exc) begin
      if (size == 4) begin
        data = rdata;
      end else if (size == 2) begin
        lane = (rdata >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
        data = (op == 3'd1 && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
      end else begin
        lane = (rdata >> (off * 8)) & 32'hFF;
        data = (op == 3'd3 && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
      end
    end
  endfunction

  // One full request/response; hold = cycles with rsp_ready low, pester = req_valid high while consuming.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [31:0] pc, input int hold,
                        input bit pester);
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
    logic        exc;
    logic [4:0]  code;
    ref_model(op, addr, rdata, we, be, data, exc, code);
    req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
    dm_rdata = rdata; rsp_ready = 1'b0; req_valid = 1'b1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_dm_we", 32'(dm_we), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("acc_dm_we", 32'(dm_we), 32'(we));
    chk("acc_dm_be", 32'(dm_be), 32'(be));
    chk("acc_dm_wdata", dm_wdata, wdata);
    chk("acc_dm_addr", dm_addr, addr);
    chk("acc_dm_pc", dm_pc, pc);
    chk("acc_req_ready", 32'(req_ready), 32'd0);
    chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, data);
    chk("rsp_exc", 32'(rsp_exc), 32'(exc));
    chk("rsp_exc_code", 32'(rsp_exc_code), 32'(code));
    chk("rsp_dm_we", 32'(dm_we), 32'd0);
    chk("rsp_dm_be", 32'(dm_be), 32'd0);
    for (int i = 0; i < hold; i++) begin
      dm_rdata = $urandom;
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", rsp_data, data);
      chk("hold_rsp_exc", 32'(rsp_exc), 32'(exc));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    if (pester) begin
      req_op = 3'd5; req_addr = 32'h0; req_valid = 1'b1;
    end
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    // Reset state
    tick(); tick();
    Reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_exc", 32'(rsp_exc), 32'd0);
    chk("rst_rsp_code", 32'(rsp_exc_code), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);

    // Directed cases
    do_txn(3'd5, 32'h0000_0010, 32'h1234_5678, 32'h0, 32'h100, 0, 1'b0);
    do_txn(3'd3, 32'h0000_0013, 32'h0, 32'h80FF_0000, 32'h104, 0, 1'b0);
    do_txn(3'd4, 32'h0000_0013, 32'h0, 32'h80FF_0000, 32'h108, 0, 1'b0);
    do_txn(3'd6, 32'h0000_0006, 32'hBEEF, 32'h0, 32'h10C, 0, 1'b0);
    do_txn(3'd1, 32'h0000_0005, 32'h0, 32'hFFFF_FFFF, 32'h110, 0, 1'b0);
    do_txn(3'd0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 32'h114, 5, 1'b1);
    do_txn(3'd5, 32'h0000_4000, 32'h5555_AAAA, 32'h0, 32'h118, 0, 1'b0);
    do_txn(3'd7, 32'h0000_0003, 32'hFF, 32'h0, 32'h11C, 0, 1'b0);
    do_txn(3'd5, 32'h0000_0002, 32'h1, 32'h0, 32'h120, 0, 1'b0);

    // Reset during the ACCESS cycle of a store
    req_op = 3'd5; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF; req_pc = 32'h200;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_dm_we", 32'(dm_we), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst_acc_dm_we", 32'(dm_we), 32'd0);
    tick();
    Reset = 1'b0;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_dm_addr", dm_addr, 32'h0);
    tick();
    chk("post_rst_idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 32'h5FFF));
      do_txn(3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DM_WORDS, default 4096, meaning number of 32-bit words in the downstream data memory (address range check bound).
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake from M stage.
REQ-005 SHALL have port req_op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
REQ-006 SHALL have ports req_addr input 32, req_wdata input 32, req_pc input 32: byte address, store data (low bits), instruction PC.
REQ-007 SHALL have ports dm_addr output 32, dm_we output 1, dm_be output 4, dm_wdata output 32, dm_pc output 32: data-memory write/read port.
REQ-008 SHALL have port dm_rdata  input  32  combinational word read of dm_addr.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-010 SHALL have ports rsp_data output 32 (extended load result, 0 for stores), rsp_exc output 1, rsp_exc_code output 5 (4 = AdEL, 5 = AdES, else 0).

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-012 SHALL, in IDLE when req_valid=1, latch op/addr/wdata/pc and go to ACCESS next cycle; otherwise stay IDLE.
REQ-013 SHALL stay in ACCESS exactly one cycle, driving dm_addr/dm_be/dm_wdata/dm_pc from latched values; dm_we = 1 only for a store with no exception.
REQ-014 SHALL generate dm_be: sw 1111; sh 0011 if addr[1]=0 else 1100; sb 0001 shifted left by addr[1:0]; loads 0000.
REQ-015 SHALL drive dm_wdata = latched req_wdata unshifted; lane placement is done by the data memory.
REQ-016 SHALL sample dm_rdata at end of ACCESS and register rsp_data: lw word; lh/lhu halfword addr[1] selects [31:16] or [15:0], sign/zero-extended; lb/lbu byte addr[1:0] selects lane, sign/zero-extended.
REQ-017 SHALL flag misalignment: lw/sw with addr[1:0]!=0, lh/lhu/sh with addr[0]=1 -> rsp_exc=1, code 4 (load) or 5 (store), dm_we=0, rsp_data=0.
REQ-018 SHALL assert rsp_valid throughout RESP, holding rsp_data/rsp_exc/rsp_exc_code stable until rsp_ready=1, then return to IDLE next cycle.
REQ-019 SHALL NOT accept a request in the cycle a response is consumed; minimum spacing of accepted requests is 3 cycles.
REQ-020 SHALL keep dm_we=0 and dm_be=0000 in IDLE and RESP.

Reset
REQ-021 SHALL, on Reset=1 at a posedge, force state IDLE, rsp_valid=0, rsp_data=0, rsp_exc=0, rsp_exc_code=0, and all latched request fields to 0, regardless of current state.
REQ-022 SHALL hold dm_we=0 in any cycle where Reset=1, so a reset during ACCESS aborts the store.
REQ-023 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-024 SHALL, with macro MAU_RANGE_CHECK_EN defined, also flag addr[31:2] >= DM_WORDS as an exception (code 4 load, 5 store), with dm_we suppressed.
REQ-025 SHALL, without MAU_RANGE_CHECK_EN, perform only alignment checks; upper address bits pass to dm_addr unchecked.

Verification
REQ-026 SHALL test sw addr 0x0000_0010 wdata 0x1234_5678 -> ACCESS cycle dm_we=1 dm_be=1111 dm_wdata=0x1234_5678; rsp_valid next cycle, rsp_exc=0.
REQ-027 SHALL test lb addr 0x0000_0013 with dm_rdata 0x80FF_0000 -> rsp_data 0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-028 SHALL test sh addr 0x0000_0006 -> dm_be=1100; lh addr 0x0000_0005 -> rsp_exc=1 code 4, dm_we=0, rsp_data=0.
REQ-029 SHALL test rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; then rsp_ready=1 -> req_ready=1 next cycle.
REQ-030 SHALL test Reset=1 asserted during ACCESS of sw -> dm_we=0 that cycle, state IDLE, rsp_valid=0 after.
REQ-031 SHALL test, with MAU_RANGE_CHECK_EN and DM_WORDS=4096, sw addr 0x0000_4000 -> rsp_exc=1 code 5, dm_we=0; without macro -> dm_we=1.
